mac_feeder: RTL and testbench

- Issue-side sequencer that drives the vector MAC kernel's input stream.
- On a start command it reads weight vectors and im2col-ordered data vectors from two single-port SRAMs (1-cycle read latency), then emits them as a valid-qualified stream.
- The stream carries one tap per output pixel for conv1x1 and nine consecutive taps per output pixel for conv3x3, matching the kernel's tap accumulation.
- Sits between the feature/weight buffers and the MAC kernel, under the layer controller.

---
 rtl/mac_feeder.sv | 189 ++++++++++++++++++
 tb/tb_mac_feeder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_feeder.sv
// mac_feeder: issue-side sequencer for the vector MAC kernel.
// On an accepted start it walks the weight and im2col data buffers (one tap
// per pixel for conv1x1, nine taps per pixel for conv3x3), issues reads to
// two single-port SRAMs with 1-cycle latency, and presents the returned
// vectors as a valid-qualified stream two cycles after each read.
module mac_feeder #(
  parameter int WI = 8,   // element width
  parameter int N  = 16,  // elements per vector
  parameter int AW = 12,  // SRAM address width
  parameter int PW = 12   // pixel-count width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_conv3x3,
  input  logic [PW-1:0]     num_pix,
  input  logic [AW-1:0]     w_base,
  input  logic [AW-1:0]     d_base,
  input  logic              stall,
  output logic              w_rd_en,
  output logic [AW-1:0]     w_rd_addr,
  input  logic [N*WI-1:0]   w_rd_data,
  output logic              d_rd_en,
  output logic [AW-1:0]     d_rd_addr,
  input  logic [N*WI-1:0]   d_rd_data,
  output logic              vld_o,
  output logic [N*WI-1:0]   win_o,
  output logic [N*WI-1:0]   din_o,
  output logic              is_conv3x3_o,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_TAP = 4'd8;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [PW-1:0]   num_pix_q, num_pix_d;
  logic [AW-1:0]   w_base_q, w_base_d;
  logic [AW-1:0]   d_base_q, d_base_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [3:0]      tap_q, tap_d;
  logic [AW-1:0]   d_off_q, d_off_d;

  // Read-enable delay line: en_d1_q marks SRAM data on the bus this cycle.
  logic            en_d1_q;
  logic            vld_q;
  logic [N*WI-1:0] win_q, din_q;

  logic accept;
  logic issue;
  logic last_issue;

  assign accept     = (state_q == S_IDLE) && start;
  assign issue      = (state_q == S_ISSUE) && !stall;
  // Last read of the command: final tap of the final pixel.
  assign last_issue = issue
                      && (mode_q ? (tap_q == LAST_TAP) : 1'b1)
                      && (pix_cnt_q == num_pix_q - PW'(1));

  // Next-state and command-level outputs of the sequencer FSM.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    w_rd_en   = issue;
    d_rd_en   = issue;
    w_rd_addr = mode_q ? (w_base_q + AW'(tap_q)) : w_base_q;
    d_rd_addr = d_base_q + d_off_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (num_pix == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last read's data is registered this cycle when en_d1_q is
        // still set; once it clears, the final vld_o is on the output.
        if (!en_d1_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Command latch and tap/pixel/data-offset counters.
  always_comb begin
    mode_d    = mode_q;
    num_pix_d = num_pix_q;
    w_base_d  = w_base_q;
    d_base_d  = d_base_q;
    pix_cnt_d = pix_cnt_q;
    tap_d     = tap_q;
    d_off_d   = d_off_q;

    if (accept) begin
      mode_d    = is_conv3x3;
      num_pix_d = num_pix;
      w_base_d  = w_base;
      d_base_d  = d_base;
      pix_cnt_d = '0;
      tap_d     = '0;
      d_off_d   = '0;
    end else if (issue) begin
      d_off_d = d_off_q + AW'(1);
      if (mode_q) begin
        if (tap_q == LAST_TAP) begin
          tap_d     = '0;
          pix_cnt_d = pix_cnt_q + PW'(1);
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end else begin
        pix_cnt_d = pix_cnt_q + PW'(1);
      end
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      num_pix_q <= '0;
      w_base_q  <= '0;
      d_base_q  <= '0;
      pix_cnt_q <= '0;
      tap_q     <= '0;
      d_off_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_pix_q <= num_pix_d;
      w_base_q  <= w_base_d;
      d_base_q  <= d_base_d;
      pix_cnt_q <= pix_cnt_d;
      tap_q     <= tap_d;
      d_off_q   <= d_off_d;
    end
  end

  // Two-stage read pipeline: enable delay and output vector registers.
  always_ff @(posedge clk) begin
    // NOTE: the wide vector registers are reset as well, so the kernel sees
    // clean zeros on win_o/din_o after reset instead of stale buffer data.
    if (rst) begin
      en_d1_q <= 1'b0;
      vld_q   <= 1'b0;
      win_q   <= '0;
      din_q   <= '0;
    end else begin
      en_d1_q <= issue;
      vld_q   <= en_d1_q;
      if (en_d1_q) begin
        win_q <= w_rd_data;
        din_q <= d_rd_data;
      end
    end
  end

  assign vld_o        = vld_q;
  assign win_o        = win_q;
  assign din_o        = din_q;
  assign is_conv3x3_o = mode_q;

endmodule

// File: tb/tb_mac_feeder.sv
// Self-checking bench for mac_feeder: SRAM models with address-derived
// contents, a scoreboard filled by the stimulus, and a monitor that checks
// reads, the output stream, per-pixel 3x3 sums and done timing.
module tb_mac_feeder;

  localparam int WI = 8;
  localparam int N  = 16;
  localparam int AW = 12;
  localparam int PW = 12;
  localparam int VW = N * WI;

  logic          clk;
  logic          rst;
  logic          start;
  logic          is_conv3x3;
  logic [PW-1:0] num_pix;
  logic [AW-1:0] w_base;
  logic [AW-1:0] d_base;
  logic          stall;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic [VW-1:0] w_rd_data;
  logic          d_rd_en;
  logic [AW-1:0] d_rd_addr;
  logic [VW-1:0] d_rd_data;
  logic          vld_o;
  logic [VW-1:0] win_o;
  logic [VW-1:0] din_o;
  logic          is_conv3x3_o;
  logic          busy;
  logic          done;

  mac_feeder #(.WI(WI), .N(N), .AW(AW), .PW(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_conv3x3   (is_conv3x3),
    .num_pix      (num_pix),
    .w_base       (w_base),
    .d_base       (d_base),
    .stall        (stall),
    .w_rd_en      (w_rd_en),
    .w_rd_addr    (w_rd_addr),
    .w_rd_data    (w_rd_data),
    .d_rd_en      (d_rd_en),
    .d_rd_addr    (d_rd_addr),
    .d_rd_data    (d_rd_data),
    .vld_o        (vld_o),
    .win_o        (win_o),
    .din_o        (din_o),
    .is_conv3x3_o (is_conv3x3_o),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer contents are a fixed function of the address.
  function automatic logic [VW-1:0] wpat(input logic [AW-1:0] a);
    logic [31:0] t;
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      t = 32'(a) * 32'd3 + 32'(a >> 8) * 32'd17 + 32'(i) * 32'd5 + 32'd1;
      v[i*WI +: WI] = t[WI-1:0];
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] dpat(input logic [AW-1:0] a);
    logic [31:0] t;
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      t = 32'(a) * 32'd7 + 32'(a >> 8) * 32'd13 + 32'(i) * 32'd11 + 32'd2;
      v[i*WI +: WI] = t[WI-1:0];
    end
    return v;
  endfunction

  function automatic int unsigned dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int unsigned s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      s += int'(a[i*WI +: WI]) * int'(b[i*WI +: WI]);
    end
    return s;
  endfunction

  // Single-port SRAM models with one cycle of read latency.
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wpat(w_rd_addr);
    if (d_rd_en) d_rd_data <= dpat(d_rd_addr);
  end

  typedef struct { logic [AW-1:0] wa; logic [AW-1:0] da; } addr_t;
  typedef struct { logic [VW-1:0] w; logic [VW-1:0] d; bit m3; } vec_t;
  typedef struct { bit after_vld; int cnt; } done_t;

  addr_t       addr_q[$];
  vec_t        vec_q[$];
  int unsigned sum_q[$];
  done_t       done_q[$];
  int          rdcyc_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected reads, vectors, 3x3 pixel sums and done for one command.
  task automatic push_expect(input bit m3, input int np,
                             input logic [AW-1:0] wb, input logic [AW-1:0] db);
    int ntaps;
    int unsigned s;
    addr_t a;
    vec_t v;
    done_t d;
    ntaps = m3 ? 9 : 1;
    for (int p = 0; p < np; p++) begin
      s = 0;
      for (int t = 0; t < ntaps; t++) begin
        a.wa = m3 ? (wb + AW'(t)) : wb;
        a.da = db + AW'(p * ntaps + t);
        addr_q.push_back(a);
        v.w  = wpat(a.wa);
        v.d  = dpat(a.da);
        v.m3 = m3;
        vec_q.push_back(v);
        s += dot(v.w, v.d);
      end
      if (m3) sum_q.push_back(s);
    end
    d.after_vld = (np != 0);
    d.cnt       = np * ntaps;
    done_q.push_back(d);
  endtask

  // Pulse start; afterwards scramble the command inputs to prove they were latched.
  task automatic start_cmd(input bit m3, input int np,
                           input logic [AW-1:0] wb, input logic [AW-1:0] db);
    @(posedge clk); #1;
    start = 1'b1; is_conv3x3 = m3; num_pix = PW'(np); w_base = wb; d_base = db;
    @(posedge clk); #1;
    start = 1'b0; is_conv3x3 = ~m3; num_pix = PW'(7); w_base = 12'hABC; d_base = 12'hDEF;
    @(negedge clk);
    if (np != 0) check_int("first_read_after_start", int'(w_rd_en), 1);
    else         check_int("zero_pix_done_next_cycle", int'(done), 1);
    check_int("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!busy && addr_q.size() == 0 && vec_q.size() == 0 && done_q.size() == 0) ok = 1'b1;
    end
    check_int({name, "_completes"}, int'(ok), 1);
  endtask

  // Monitor: compares every read, output vector and done against the scoreboard.
  addr_t mon_a;
  vec_t  mon_v;
  done_t mon_d;
  int          vld_cnt  = 0;
  int          tap_seen = 0;
  int unsigned acc      = 0;
  bit          prev_vld = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      addr_q.delete(); vec_q.delete(); sum_q.delete(); done_q.delete(); rdcyc_q.delete();
      vld_cnt = 0; tap_seen = 0; acc = 0; prev_vld = 1'b0;
    end else begin
      if (w_rd_en || d_rd_en) begin
        check_int("rd_en_pair", int'({w_rd_en, d_rd_en}), 3);
        if (addr_q.size() == 0) begin
          check_int("unexpected_read", 1, 0);
        end else begin
          mon_a = addr_q.pop_front();
          check_int("w_rd_addr", int'(w_rd_addr), int'(mon_a.wa));
          check_int("d_rd_addr", int'(d_rd_addr), int'(mon_a.da));
        end
        rdcyc_q.push_back(cyc);
      end
      if (vld_o) begin
        vld_cnt++;
        if (vec_q.size() == 0) begin
          check_int("unexpected_vld", 1, 0);
        end else begin
          mon_v = vec_q.pop_front();
          check("win_o", win_o, mon_v.w);
          check("din_o", din_o, mon_v.d);
          check_int("is_conv3x3_o", int'(is_conv3x3_o), int'(mon_v.m3));
          if (rdcyc_q.size() != 0) check_int("vld_latency", cyc - rdcyc_q.pop_front(), 2);
          if (mon_v.m3) begin
            acc += dot(win_o, din_o);
            tap_seen++;
            if (tap_seen == 9) begin
              if (sum_q.size() == 0) check_int("unexpected_pixel_sum", 1, 0);
              else check_int("pixel_sum", int'(acc), int'(sum_q.pop_front()));
              acc = 0;
              tap_seen = 0;
            end
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check_int("unexpected_done", 1, 0);
        end else begin
          mon_d = done_q.pop_front();
          check_int("done_one_after_last_vld", int'(prev_vld), int'(mon_d.after_vld));
          check_int("vld_count", vld_cnt, mon_d.cnt);
          check_int("stream_drained_at_done", addr_q.size() + vec_q.size(), 0);
        end
        vld_cnt = 0;
      end
      prev_vld = vld_o;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  nreads;
    bit  seen_done;
    rst = 1'b1; start = 1'b0; is_conv3x3 = 1'b0; num_pix = '0;
    w_base = '0; d_base = '0; stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_vld_o", int'(vld_o), 0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_rd_en", int'({w_rd_en, d_rd_en}), 0);
    check_int("reset_addrs", int'({w_rd_addr, d_rd_addr}), 0);
    check("reset_win_o", win_o, '0);
    check("reset_din_o", din_o, '0);
    check_int("reset_is_conv3x3_o", int'(is_conv3x3_o), 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1x1, four pixels: d 0x100..0x103, w fixed at 0x010.
    push_expect(1'b0, 4, 12'h010, 12'h100);
    start_cmd(1'b0, 4, 12'h010, 12'h100);
    wait_idle("conv1x1_4pix");

    // 3x3, two pixels from base 0: w 0..8 twice, d 0..17.
    push_expect(1'b1, 2, 12'h000, 12'h000);
    start_cmd(1'b1, 2, 12'h000, 12'h000);
    wait_idle("conv3x3_2pix");

    // 3x3, one pixel, stall during issue cycles 3-5.
    push_expect(1'b1, 1, 12'h005, 12'h040);
    start_cmd(1'b1, 1, 12'h005, 12'h040);
    @(posedge clk); #1;
    @(posedge clk); #1 stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_int("stall_blocks_read", int'({w_rd_en, d_rd_en}), 0);
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1 stall = 1'b0;
    wait_idle("conv3x3_stall");

    // Zero-pixel command: no reads, done next cycle, then idle.
    push_expect(1'b0, 0, 12'h123, 12'h456);
    start_cmd(1'b0, 0, 12'h123, 12'h456);
    @(negedge clk);
    check_int("zero_pix_busy_clears", int'(busy), 0);
    wait_idle("zero_pix");

    // 3x3, three pixels; starts during ISSUE and during DONE are ignored.
    push_expect(1'b1, 3, 12'h7F8, 12'h200);
    start_cmd(1'b1, 3, 12'h7F8, 12'h200);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; is_conv3x3 = 1'b0; num_pix = PW'(5); w_base = 12'h111; d_base = 12'h222;
    @(posedge clk); #1 start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check_int("done_reached_for_busy_start", int'(seen_done), 1);
    start = 1'b1; is_conv3x3 = 1'b0; num_pix = PW'(2); w_base = 12'h333; d_base = 12'h444;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("start_ignored_while_busy");
    check_int("mode_held_between_cmds", int'(is_conv3x3_o), 1);

    // Later start is accepted; data address wraps past the top of the buffer.
    push_expect(1'b0, 4, 12'h0AB, 12'hFFE);
    start_cmd(1'b0, 4, 12'h0AB, 12'hFFE);
    wait_idle("start_after_done_wrap");

    // Reset after five issued reads aborts the command.
    push_expect(1'b1, 2, 12'h020, 12'h300);
    start_cmd(1'b1, 2, 12'h020, 12'h300);
    nreads = 1;
    for (int i = 0; i < 50 && nreads < 5; i++) begin
      @(negedge clk);
      if (w_rd_en) nreads++;
    end
    check_int("five_reads_issued", nreads, 5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_int("abort_vld_o", int'(vld_o), 0);
    check_int("abort_busy", int'(busy), 0);
    check_int("abort_rd_en", int'({w_rd_en, d_rd_en}), 0);
    check_int("abort_is_conv3x3_o", int'(is_conv3x3_o), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_int("no_done_after_abort", int'({done, vld_o}), 0);
    end
    push_expect(1'b0, 3, 12'h044, 12'h7F0);
    start_cmd(1'b0, 3, 12'h044, 12'h7F0);
    wait_idle("fresh_cmd_after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
